// File: rtl/vga_pkg.sv
// Shared widths, screen geometry and arbiter state encoding for the VGA plot path.
package vga_pkg;
    localparam int X_W      = 9;
    localparam int Y_W      = 8;
    localparam int C_W      = 3;
    localparam int SCREEN_W = 160;
    localparam int SCREEN_H = 120;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_e;
endpackage

// File: rtl/vga_plot_arbiter_if.sv
// Producer-side bundle: per-requester request, pixel payload and returned grant.
interface vga_plot_arbiter_if #(
    parameter int N_REQ = 3
);
    import vga_pkg::*;

    logic [N_REQ-1:0]       req;
    logic [X_W*N_REQ-1:0]   req_x;
    logic [Y_W*N_REQ-1:0]   req_y;
    logic [C_W*N_REQ-1:0]   req_colour;
    logic [N_REQ-1:0]       gnt;

    modport master (output req, req_x, req_y, req_colour, input gnt);
    modport slave  (input req, req_x, req_y, req_colour, output gnt);
endinterface

// File: rtl/vga_plot_arbiter_rr_pick.sv
// Combinational round-robin picker: first set req bit at or above ptr, wrapping.
module rr_pick #(
    parameter int N     = 3,
    parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N-1:0]     win_oh,
    output logic [PTR_W-1:0] win_idx,
    output logic             any
);
    logic found;
    int   j;

    always_comb begin
        win_oh  = '0;
        win_idx = '0;
        found   = 1'b0;
        j       = 0;
        for (int k = 0; k < N; k++) begin
            j = (int'(ptr) + k) % N;
            if (!found && req[j]) begin
                found      = 1'b1;
                win_oh[j]  = 1'b1;
                win_idx    = PTR_W'(j);
            end
        end
    end

    assign any = |req;
endmodule

// File: rtl/vga_plot_arbiter.sv
// Round-robin, burst-limited arbiter sharing the VGA framebuffer write port.
// state | meaning
// IDLE  | no owner, gnt = 0
// GRANT | owner_q holds the port, gnt = onehot(owner_q)
module vga_plot_arbiter
    import vga_pkg::*;
#(
    parameter int N_REQ     = 3,
    parameter int MAX_BURST = 160,
    parameter int SCREEN_W  = vga_pkg::SCREEN_W,
    parameter int SCREEN_H  = vga_pkg::SCREEN_H
) (
    input  logic                Clock,
    input  logic                Resetn,
    vga_plot_arbiter_if.slave   prod,
    output logic                plot,
    output logic [X_W-1:0]      plot_x,
    output logic [Y_W-1:0]      plot_y,
    output logic [C_W-1:0]      plot_colour,
    output logic [7:0]          drop_count
);
    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam logic [8:0]     BURST_LAST = 9'(MAX_BURST - 1);
    localparam logic [X_W-1:0] X_LIM      = X_W'(SCREEN_W);
    localparam logic [Y_W-1:0] Y_LIM      = Y_W'(SCREEN_H);

    arb_state_e        state_q, state_d;
    logic [PTR_W-1:0]  owner_q, owner_d;
    logic [PTR_W-1:0]  ptr_q, ptr_d;
    logic [8:0]        burst_q, burst_d;
    logic [N_REQ-1:0]  gnt_q, gnt_d;
    logic              plot_q, plot_d;
    logic [X_W-1:0]    x_q, x_d;
    logic [Y_W-1:0]    y_q, y_d;
    logic [C_W-1:0]    c_q, c_d;
    logic [7:0]        drop_q, drop_d;

    logic [N_REQ-1:0]  win_oh;
    logic [PTR_W-1:0]  win_idx;
    logic              any_req;
    logic              xfer, others, take_new, on_screen;
    logic [X_W-1:0]    cur_x;
    logic [Y_W-1:0]    cur_y;
    logic [C_W-1:0]    cur_c;

    rr_pick #(.N(N_REQ), .PTR_W(PTR_W)) u_pick (
        .req     (prod.req),
        .ptr     (ptr_q),
        .win_oh  (win_oh),
        .win_idx (win_idx),
        .any     (any_req)
    );

    always_comb begin
        cur_x     = prod.req_x[int'(owner_q)*X_W +: X_W];
        cur_y     = prod.req_y[int'(owner_q)*Y_W +: Y_W];
        cur_c     = prod.req_colour[int'(owner_q)*C_W +: C_W];
        xfer      = (state_q == GRANT) && prod.req[owner_q];
        others    = |(prod.req & ~gnt_q);
        on_screen = (cur_x < X_LIM) && (cur_y < Y_LIM);

        state_d  = state_q;
        owner_d  = owner_q;
        ptr_d    = ptr_q;
        burst_d  = burst_q;
        take_new = 1'b0;

        case (state_q)
            IDLE: take_new = any_req;
            GRANT: begin
                if (xfer) begin
                    if (burst_q < BURST_LAST)
                        burst_d = burst_q + 9'd1;
                    else if (others)
                        take_new = 1'b1;
                    else
                        burst_d = '0;
                end else if (any_req) begin
                    take_new = 1'b1;
                end else begin
                    state_d = IDLE;
                    burst_d = '0;
                end
            end
            default: state_d = IDLE;
        endcase

        // ptr sits just past the owner, so the owner is searched last on re-arbitration
        if (take_new) begin
            state_d = GRANT;
            owner_d = win_idx;
            burst_d = '0;
            ptr_d   = (int'(win_idx) == N_REQ - 1) ? '0 : win_idx + PTR_W'(1);
        end

        gnt_d = (state_d == GRANT) ? (N_REQ'(1) << owner_d) : '0;

        plot_d = 1'b0;
        x_d    = x_q;
        y_d    = y_q;
        c_d    = c_q;
        drop_d = drop_q;
        if (xfer) begin
            if (on_screen) begin
                plot_d = 1'b1;
                x_d    = cur_x;
                y_d    = cur_y;
                c_d    = cur_c;
            end else if (drop_q != 8'hFF) begin
                drop_d = drop_q + 8'd1;
            end
        end
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state_q <= IDLE;
            owner_q <= '0;
            ptr_q   <= '0;
            burst_q <= '0;
            gnt_q   <= '0;
            plot_q  <= 1'b0;
            x_q     <= '0;
            y_q     <= '0;
            c_q     <= '0;
            drop_q  <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            burst_q <= burst_d;
            gnt_q   <= gnt_d;
            plot_q  <= plot_d;
            x_q     <= x_d;
            y_q     <= y_d;
            c_q     <= c_d;
            drop_q  <= drop_d;
        end
    end

    assign prod.gnt    = gnt_q;
    assign plot        = plot_q;
    assign plot_x      = x_q;
    assign plot_y      = y_q;
    assign plot_colour = c_q;
    assign drop_count  = drop_q;
endmodule

// File: tb/tb_vga_plot_arbiter.sv
// Randomized and directed bench for vga_plot_arbiter against a cycle-level reference model.
module tb_vga_plot_arbiter;
    localparam int N  = 3;
    localparam int MB = 4;
    localparam int SW = 160;
    localparam int SH = 120;

    logic       Clock = 1'b0;
    logic       Resetn;
    logic       plot;
    logic [8:0] plot_x;
    logic [7:0] plot_y;
    logic [2:0] plot_colour;
    logic [7:0] drop_count;

    vga_plot_arbiter_if #(.N_REQ(N)) ifc ();

    vga_plot_arbiter #(.N_REQ(N), .MAX_BURST(MB), .SCREEN_W(SW), .SCREEN_H(SH)) dut (
        .Clock       (Clock),
        .Resetn      (Resetn),
        .prod        (ifc),
        .plot        (plot),
        .plot_x      (plot_x),
        .plot_y      (plot_y),
        .plot_colour (plot_colour),
        .drop_count  (drop_count)
    );

    always #5 Clock = ~Clock;

    int checks   = 0;
    int failures = 0;

    logic [N-1:0] s_req;
    int s_x [N];
    int s_y [N];
    int s_c [N];

    int m_owner, m_burst, m_ptr, m_plot, m_x, m_y, m_c, m_drop;
    int m_gnt;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int pick(input logic [N-1:0] r, input int p);
        for (int k = 0; k < N; k++)
            if (r[(p + k) % N]) return (p + k) % N;
        return -1;
    endfunction

    task automatic model_reset();
        m_owner = -1; m_burst = 0; m_ptr = 0;
        m_plot = 0; m_x = 0; m_y = 0; m_c = 0; m_drop = 0; m_gnt = 0;
    endtask

    task automatic grant_to(input int w);
        m_owner = w;
        m_burst = 0;
        m_ptr   = (w + 1) % N;
    endtask

    // One clock edge of the arbiter's behaviour, given the inputs now on the bus.
    task automatic model_step();
        bit xfer;
        int w;
        logic [N-1:0] rest;
        xfer = (m_owner >= 0) && s_req[m_owner];
        m_plot = 0;
        if (xfer) begin
            if (s_x[m_owner] < SW && s_y[m_owner] < SH) begin
                m_plot = 1;
                m_x = s_x[m_owner]; m_y = s_y[m_owner]; m_c = s_c[m_owner];
            end else if (m_drop < 255) begin
                m_drop = m_drop + 1;
            end
        end
        w = pick(s_req, m_ptr);
        if (m_owner < 0) begin
            if (w >= 0) grant_to(w);
        end else if (xfer) begin
            rest = s_req;
            rest[m_owner] = 1'b0;
            if (m_burst < MB - 1)  m_burst = m_burst + 1;
            else if (rest != 0)    grant_to(w);
            else                   m_burst = 0;
        end else begin
            if (w >= 0) grant_to(w);
            else begin m_owner = -1; m_burst = 0; end
        end
        m_gnt = (m_owner < 0) ? 0 : (1 << m_owner);
    endtask

    task automatic drive();
        ifc.req = s_req;
        for (int i = 0; i < N; i++) begin
            ifc.req_x[9*i +: 9]      = 9'(s_x[i]);
            ifc.req_y[8*i +: 8]      = 8'(s_y[i]);
            ifc.req_colour[3*i +: 3] = 3'(s_c[i]);
        end
    endtask

    task automatic check_outs();
        check_eq("gnt", 32'(ifc.gnt), 32'(m_gnt));
        check_eq("plot", 32'(plot), 32'(m_plot));
        check_eq("plot_x", 32'(plot_x), 32'(m_x));
        check_eq("plot_y", 32'(plot_y), 32'(m_y));
        check_eq("plot_colour", 32'(plot_colour), 32'(m_c));
        check_eq("drop_count", 32'(drop_count), 32'(m_drop));
    endtask

    task automatic cycle();
        @(negedge Clock);
        check_outs();
        drive();
        model_step();
    endtask

    task automatic set_px(input int i, input int x, input int y, input int c);
        s_x[i] = x; s_y[i] = y; s_c[i] = c;
    endtask

    task automatic idle(input int n);
        s_req = '0;
        for (int k = 0; k < n; k++) cycle();
    endtask

    initial begin
        Resetn = 1'b0;
        s_req  = '0;
        for (int i = 0; i < N; i++) set_px(i, 0, 0, 0);
        drive();
        model_reset();
        #12 Resetn = 1'b1;

        // single requester, x = 0..9 on y = 5
        s_req = 3'b001;
        for (int k = 0; k < 10; k++) begin
            set_px(0, k, 5, 7);
            cycle();
        end
        s_req = '0;
        set_px(0, 9, 5, 7);
        cycle();
        cycle();
        check_eq("t1_last_x", 32'(plot_x), 32'd9);
        idle(2);

        // requesters 0 and 2 together, then 0 drops
        set_px(0, 20, 30, 1);
        set_px(2, 40, 50, 4);
        s_req = 3'b101;
        for (int k = 0; k < 3; k++) cycle();
        s_req = 3'b100;
        for (int k = 0; k < 3; k++) cycle();
        idle(3);

        // burst limit alternation between 0 and 1
        s_req = 3'b011;
        for (int k = 0; k < 18; k++) begin
            set_px(0, k, 1, 2);
            set_px(1, 100 + k, 2, 3);
            cycle();
        end
        idle(3);

        // lone requester keeps the grant past the burst limit
        s_req = 3'b010;
        for (int k = 0; k < 13; k++) begin
            set_px(1, k, 9, 6);
            cycle();
        end
        idle(3);

        // randomized traffic with sticky requests
        for (int k = 0; k < 500; k++) begin
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(0, 5) == 0) s_req[i] = ~s_req[i];
                set_px(i, int'($urandom_range(0, 175)), int'($urandom_range(0, 130)),
                       int'($urandom_range(0, 7)));
            end
            cycle();
        end
        idle(3);

        // reset asserted mid-burst
        s_req = 3'b001;
        for (int k = 0; k < 6; k++) begin
            set_px(0, k + 1, 7, 5);
            cycle();
        end
        @(negedge Clock);
        #2 Resetn = 1'b0;
        #1;
        check_eq("rst_gnt", 32'(ifc.gnt), 32'd0);
        check_eq("rst_plot", 32'(plot), 32'd0);
        check_eq("rst_drop", 32'(drop_count), 32'd0);
        check_eq("rst_plot_x", 32'(plot_x), 32'd0);
        model_reset();
        s_req = '0;
        drive();
        Resetn = 1'b1;
        model_step();
        s_req = 3'b001;
        set_px(0, 11, 12, 3);
        cycle();
        cycle();
        check_eq("regrant", 32'(ifc.gnt), 32'd1);
        idle(3);

        // off-screen drops
        s_req = 3'b001;
        set_px(0, 160, 0, 1);
        cycle();
        cycle();
        set_px(0, 3, 120, 2);
        cycle();
        set_px(0, 159, 119, 5);
        cycle();
        s_req = '0;
        cycle();
        cycle();
        check_eq("drop2", 32'(drop_count), 32'd2);
        check_eq("onscreen_x", 32'(plot_x), 32'd159);
        check_eq("onscreen_y", 32'(plot_y), 32'd119);
        s_req = 3'b001;
        set_px(0, 300, 10, 0);
        for (int k = 0; k < 302; k++) cycle();
        idle(2);
        check_eq("drop_sat", 32'(drop_count), 32'd255);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
